// File: rtl/instruction_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// The queue connects through the slave modport; the fetch/decode side uses master.
interface instruction_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            flush_in;
    logic            fetch_valid_in;
    logic [XLEN-1:0] fetch_pc_in;
    logic [XLEN-1:0] fetch_ins_in;
    logic            fetch_ready_out;
    logic            dec_valid_out;
    logic            dec_ready_in;
    logic [XLEN-1:0] dec_pc_out;
    logic [XLEN-1:0] dec_ins_out;
    logic [4:0]      opcode_out;
    logic [2:0]      funct3_out;
    logic [6:0]      funct7_out;
    logic [4:0]      rs1_out;
    logic [4:0]      rs2_out;
    logic [4:0]      rd_out;
    logic            ins_len_err_out;
    logic [CW-1:0]   count_out;

    modport slave (
        input  flush_in, fetch_valid_in, fetch_pc_in, fetch_ins_in, dec_ready_in,
        output fetch_ready_out, dec_valid_out, dec_pc_out, dec_ins_out,
               opcode_out, funct3_out, funct7_out, rs1_out, rs2_out, rd_out,
               ins_len_err_out, count_out
    );

    modport master (
        output flush_in, fetch_valid_in, fetch_pc_in, fetch_ins_in, dec_ready_in,
        input  fetch_ready_out, dec_valid_out, dec_pc_out, dec_ins_out,
               opcode_out, funct3_out, funct7_out, rs1_out, rs2_out, rd_out,
               ins_len_err_out, count_out
    );
endinterface

// File: rtl/instruction_queue.sv
// Circular instruction queue between fetch and decode, with registered-only
// output path (no fall-through) and a NOP presented whenever it is empty.
module instruction_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic              clock_in,
    input  logic              reset_in,
    instruction_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic [XLEN-1:0] ins_mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] head_ins;

    // Handshake qualification; a full queue never accepts, even alongside a pop.
    always_comb begin
        bus.fetch_ready_out = (count < CW'(DEPTH));
        bus.dec_valid_out   = (count != '0);
        push = bus.fetch_valid_in && bus.fetch_ready_out;
        pop  = bus.dec_valid_out && bus.dec_ready_in;
    end

    // Pointer and occupancy update; reset beats flush, flush beats push/pop.
    always_ff @(posedge clock_in) begin
        if (reset_in || bus.flush_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Entry storage is unreset; a write discarded by flush/reset is never visible.
    always_ff @(posedge clock_in) begin
        if (push) begin
            pc_mem[tail]  <= bus.fetch_pc_in;
            ins_mem[tail] <= bus.fetch_ins_in;
        end
    end

    // Decode view of the head entry, substituting a NOP when empty.
    always_comb begin
        head_ins        = bus.dec_valid_out ? ins_mem[head] : NOP;
        bus.dec_ins_out = head_ins;
        bus.dec_pc_out  = bus.dec_valid_out ? pc_mem[head] : '0;
        bus.opcode_out  = head_ins[6:2];
        bus.funct3_out  = head_ins[14:12];
        bus.funct7_out  = head_ins[31:25];
        bus.rs1_out     = head_ins[19:15];
        bus.rs2_out     = head_ins[24:20];
        bus.rd_out      = head_ins[11:7];
        bus.ins_len_err_out = bus.dec_valid_out && (head_ins[1:0] != 2'b11);
        bus.count_out   = count;
    end
endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: a queue-based reference model checked
// every cycle, plus hand-computed literal checks at key points.
module tb_instruction_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    typedef struct { logic [31:0] pc; logic [31:0] ins; } entry_t;
    entry_t model_q[$];
    bit     model_live = 1'b0;

    instruction_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

    instruction_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock_in (clk),
        .reset_in (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a plain FIFO obeying the accept/consume rules.
    always @(posedge clk) begin
        automatic bit do_pop;
        automatic bit do_push;
        automatic entry_t e;
        if (rst) begin
            model_q.delete();
            model_live = 1'b1;
        end else if (bus.flush_in) begin
            model_q.delete();
        end else begin
            do_pop  = (model_q.size() > 0) && bus.dec_ready_in;
            do_push = bus.fetch_valid_in && (model_q.size() < DEPTH);
            e.pc  = bus.fetch_pc_in;
            e.ins = bus.fetch_ins_in;
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(e);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle away from the edge.
    always @(negedge clk) begin
        automatic logic [31:0] ei;
        automatic logic [31:0] ep;
        automatic bit nonempty;
        if (model_live) begin
            nonempty = model_q.size() > 0;
            ei = nonempty ? model_q[0].ins : 32'h0000_0013;
            ep = nonempty ? model_q[0].pc  : 32'h0;
            chk("m_count",  32'(bus.count_out),       32'(model_q.size()));
            chk("m_fready", 32'(bus.fetch_ready_out), 32'(model_q.size() < DEPTH));
            chk("m_dvalid", 32'(bus.dec_valid_out),   32'(nonempty));
            chk("m_pc",     bus.dec_pc_out,           ep);
            chk("m_ins",    bus.dec_ins_out,          ei);
            chk("m_opcode", 32'(bus.opcode_out),      32'(ei[6:2]));
            chk("m_funct3", 32'(bus.funct3_out),      32'(ei[14:12]));
            chk("m_funct7", 32'(bus.funct7_out),      32'(ei[31:25]));
            chk("m_rs1",    32'(bus.rs1_out),         32'(ei[19:15]));
            chk("m_rs2",    32'(bus.rs2_out),         32'(ei[24:20]));
            chk("m_rd",     32'(bus.rd_out),          32'(ei[11:7]));
            chk("m_lenerr", 32'(bus.ins_len_err_out), 32'(nonempty && ei[1:0] != 2'b11));
        end
    end

    // Apply one cycle of inputs, then settle just after the next rising edge.
    task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                        input bit rdy, input bit fl, input bit rs);
        bus.fetch_valid_in = v;
        bus.fetch_pc_in    = pc;
        bus.fetch_ins_in   = ins;
        bus.dec_ready_in   = rdy;
        bus.flush_in       = fl;
        rst                = rs;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] prog [10];

    initial begin
        prog = '{32'h0050_0093, 32'h00a0_0113, 32'h00f0_0193, 32'h0140_0213,
                 32'h0190_0293, 32'h01e0_0313, 32'h0230_0393, 32'h0280_0413,
                 32'h02d0_0493, 32'h0320_0513};
        step(0, 0, 0, 0, 0, 1);
        chk("rst_count",  32'(bus.count_out), 0);
        chk("rst_fready", 32'(bus.fetch_ready_out), 1);
        chk("rst_dvalid", 32'(bus.dec_valid_out), 0);
        chk("rst_nop",    bus.dec_ins_out, 32'h0000_0013);

        // Fill to full with decode stalled.
        for (int i = 0; i < 4; i++) step(1, 32'(4 * i), prog[i], 0, 0, 0);
        chk("full_count",  32'(bus.count_out), 4);
        chk("full_fready", 32'(bus.fetch_ready_out), 0);
        chk("full_pc",     bus.dec_pc_out, 32'h0);
        chk("full_opcode", 32'(bus.opcode_out), 32'h04);
        chk("full_rd",     32'(bus.rd_out), 1);

        // Push attempted into full queue alongside a pop: only the pop happens.
        step(1, 32'h10, 32'h0370_0593, 1, 0, 0);
        chk("fullpp_count", 32'(bus.count_out), 3);
        chk("fullpp_pc",    bus.dec_pc_out, 32'h4);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
        chk("drain_count", 32'(bus.count_out), 0);
        chk("drain_nop",   bus.dec_ins_out, 32'h0000_0013);

        // Pop while empty has no effect.
        step(0, 0, 0, 1, 0, 0);
        chk("emptypop_count", 32'(bus.count_out), 0);

        // Streaming across pointer wrap: head always the freshly pushed entry.
        for (int i = 0; i < 10; i++) begin
            step(1, 32'(4 * i), prog[i], 1, 0, 0);
            chk("stream_count", 32'(bus.count_out), 1);
            chk("stream_pc",    bus.dec_pc_out, 32'(4 * i));
        end
        step(0, 0, 0, 1, 0, 0);
        chk("stream_end", 32'(bus.count_out), 0);

        // Flush with simultaneous push discards everything.
        for (int i = 0; i < 3; i++) step(1, 32'(32'h40 + 4 * i), prog[i], 0, 0, 0);
        chk("preflush_count", 32'(bus.count_out), 3);
        step(1, 32'h4c, prog[3], 0, 1, 0);
        chk("flush_count",  32'(bus.count_out), 0);
        chk("flush_dvalid", 32'(bus.dec_valid_out), 0);
        chk("flush_nop",    bus.dec_ins_out, 32'h0000_0013);

        // Compressed-looking encoding flags a length error only while queued.
        step(1, 32'h80, 32'h0000_0001, 0, 0, 0);
        chk("lenerr_set",  32'(bus.ins_len_err_out), 1);
        step(0, 0, 0, 1, 0, 0);
        chk("lenerr_clr",  32'(bus.ins_len_err_out), 0);

        // Reset beats flush and push mid-operation.
        step(1, 32'h90, prog[4], 0, 0, 0);
        step(1, 32'h94, prog[5], 0, 0, 0);
        chk("prerst_count", 32'(bus.count_out), 2);
        step(1, 32'h98, prog[6], 0, 1, 1);
        chk("midrst_count",  32'(bus.count_out), 0);
        chk("midrst_fready", 32'(bus.fetch_ready_out), 1);

        // Refill after reset with partial pops to exercise mixed traffic.
        step(1, 32'hA0, prog[7], 0, 0, 0);
        step(1, 32'hA4, prog[8], 1, 0, 0);
        step(1, 32'hA8, prog[9], 0, 0, 0);
        chk("mix_pc", bus.dec_pc_out, 32'hA4);
        step(0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_queue.md
INSTRUCTION_QUEUE -- requirements
Module: INSTRUCTION_QUEUE

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; legal values are powers of two, 2..16.
REQ-002 Parameter XLEN, default 32, width of PC and instruction words.
REQ-003 clock_in  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_in  input  1  synchronous, active-high reset.
REQ-005 flush_in  input  1  synchronous queue flush (branch/jump redirect).
REQ-006 fetch_valid_in  input  1  fetch stage presents an instruction.
REQ-007 fetch_pc_in  input  XLEN  PC of the presented instruction.
REQ-008 fetch_ins_in  input  XLEN  presented instruction word.
REQ-009 fetch_ready_out  output  1  queue can accept an instruction this cycle.
REQ-010 dec_valid_out  output  1  head entry valid for decode.
REQ-011 dec_ready_in  input  1  decode consumes the head entry this cycle.
REQ-012 dec_pc_out  output  XLEN  PC of head entry.
REQ-013 dec_ins_out  output  XLEN  instruction word of head entry.
REQ-014 opcode_out  output  5  head ins[6:2], feeds decode opcode input.
REQ-015 funct3_out  output  3  head ins[14:12].
REQ-016 funct7_out  output  7  head ins[31:25].
REQ-017 rs1_out, rs2_out, rd_out  output  5 each  head ins[19:15], ins[24:20], ins[11:7].
REQ-018 ins_len_err_out  output  1  head ins[1:0] != 2'b11 while dec_valid_out = 1 (non-32-bit encoding).
REQ-019 count_out  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-020 The queue SHALL be a circular buffer of DEPTH entries {pc, ins} with head pointer, tail pointer (log2(DEPTH) bits, wrap modulo DEPTH) and occupancy count.
REQ-021 Push SHALL occur when fetch_valid_in = 1 and fetch_ready_out = 1: entry written at tail, tail increments.
REQ-022 Pop SHALL occur when dec_valid_out = 1 and dec_ready_in = 1: head increments.
REQ-023 fetch_ready_out SHALL be 1 exactly when count < DEPTH; no same-cycle push into a full queue even if a pop occurs.
REQ-024 dec_valid_out SHALL be 1 exactly when count > 0.
REQ-025 Count update: push only +1; pop only -1; push and pop together unchanged; neither unchanged.
REQ-026 Latency: a pushed entry SHALL appear at the decode outputs no earlier than the cycle after the push (no combinational fall-through, even when empty).
REQ-027 Decode outputs (dec_pc_out, dec_ins_out and field slices) SHALL be combinational from the head entry while count > 0.
REQ-028 When count = 0, dec_ins_out SHALL be 32'h00000013 (NOP), dec_pc_out 0, slices derived from that NOP, ins_len_err_out 0.
REQ-029 Pointers SHALL wrap from DEPTH-1 to 0 without loss or duplication of entries.
REQ-030 Pop with dec_ready_in = 1 while empty SHALL have no effect.
REQ-031 Push with fetch_valid_in = 1 while full SHALL be ignored; fetch stage holds the instruction.
REQ-032 flush_in = 1 SHALL take priority over push and pop: next cycle count = 0, head = tail = 0; any same-cycle push is discarded.
REQ-033 Entry storage SHALL not require reset; only pointers and count are reset/flushed.

Reset
REQ-034 reset_in = 1 at a rising edge SHALL set head = 0, tail = 0, count = 0, giving dec_valid_out = 0, fetch_ready_out = 1, count_out = 0, NOP decode outputs.
REQ-035 reset_in SHALL take priority over flush_in, push and pop; reset mid-operation discards all entries.

Verification
REQ-036 Reset, then push PC 0x00,0x04,0x08,0x0C (ins 0x00500093 etc.) on consecutive cycles, dec_ready_in = 0 -> count_out 4, fetch_ready_out 0, dec_pc_out 0x00, opcode_out 5'b00100, rd_out 1.
REQ-037 Full queue, fetch_valid_in = 1 and dec_ready_in = 1 same cycle -> pop only, count_out 3, pushed instruction not stored.
REQ-038 Continuous push/pop for 10 instructions with PC 0x00..0x24 -> decode sees PCs in order with no gaps across pointer wrap, count stays 1 after first push.
REQ-039 Three entries queued, flush_in = 1 with simultaneous push -> next cycle count_out 0, dec_valid_out 0, dec_ins_out 0x00000013.
REQ-040 Push ins 0x00000001 -> next cycle ins_len_err_out 1; pop it -> ins_len_err_out 0 when empty.
REQ-041 Two entries queued, reset_in = 1 with flush_in = 1 and push -> next cycle count_out 0, fetch_ready_out 1.
